// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the miniRV fetch sequencer.
package fetch_sequencer_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_PC_STEP  = 32'h0000_0004;

    // Fetch FSM encodings
    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fetch_state_e;

    // Redirect targets are always word aligned; low two bits are discarded.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    // Sequential PC advance; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc,
                                                input logic [PC_W-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the instruction-memory, decode and redirect signals of the fetch sequencer.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    // Instruction memory side
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    // Decode side
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_ready;

    // Branch/jump redirect
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;

    // Observability
    logic [PC_W-1:0]   pc_cur;

    // The fetch sequencer itself
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_cur,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );

    // Memory, decode and branch unit surrounding the sequencer
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_cur,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_sequencer_fetch_buf.sv
// One-entry valid/ready holding register between fetch and decode.
// A flush (redirect) wins over a load; a load in the same cycle as a pop keeps the entry valid.
module fetch_sequencer_fetch_buf
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [INST_W-1:0] data_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              valid,
    output logic [INST_W-1:0] data,
    output logic [PC_W-1:0]   pc
);

    // Entry state: flush clears, load captures, a consumed entry empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= {INST_W{1'b0}};
            pc    <= {PC_W{1'b0}};
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            pc    <= pc_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and instruction fetch sequencer for the miniRV core.
// One outstanding imem request at a time; a kill flag marks an in-flight
// response that a redirect has made stale so it is dropped on arrival.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.master bus
);

    fetch_state_e      state_r;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   inflight_pc_r;
    logic              kill_r;

    logic              req_s;
    logic              fire_s;
    logic              resp_s;
    logic              load_s;
    logic [PC_W-1:0]   target_s;

    logic              buf_valid;
    logic [INST_W-1:0] buf_data;
    logic [PC_W-1:0]   buf_pc;

    // Request gating, handshake qualifiers and the buffer load decision.
    always_comb begin
        req_s = 1'b0;
        if (state_r == FS_REQ) begin
            // Only fetch when the decode buffer has room or is draining now.
            req_s = !buf_valid || bus.inst_ready;
        end else begin
            req_s = 1'b0;
        end
        fire_s   = req_s && bus.imem_gnt;
        resp_s   = (state_r == FS_WAIT) && bus.imem_rvalid;
        // A same-cycle redirect or a pending kill discards the response.
        load_s   = resp_s && !kill_r && !bus.redirect_valid;
        target_s = pc_align(bus.redirect_pc);
    end

    // Fetch FSM: owns pc_cur, the in-flight PC and the stale-response kill flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= FS_BOOT;
            pc_r          <= RESET_PC;
            inflight_pc_r <= {PC_W{1'b0}};
            kill_r        <= 1'b0;
        end else begin
            case (state_r)
                FS_BOOT: begin
                    // No fetch in the first cycle; a redirect here retargets the first fetch.
                    state_r <= FS_REQ;
                    if (bus.redirect_valid) begin
                        pc_r <= target_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                FS_REQ: begin
                    if (fire_s) begin
                        state_r       <= FS_WAIT;
                        inflight_pc_r <= pc_r;
                        // The request just granted fetches the old path.
                        kill_r        <= bus.redirect_valid;
                    end else begin
                        state_r <= FS_REQ;
                    end
                    if (bus.redirect_valid) begin
                        pc_r <= target_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                FS_WAIT: begin
                    if (resp_s) begin
                        state_r <= FS_REQ;
                        kill_r  <= 1'b0;
                        if (bus.redirect_valid) begin
                            // Response consumed and dropped here, so no kill is needed.
                            pc_r <= target_s;
                        end else if (!kill_r) begin
                            pc_r <= pc_incr(pc_r, PC_STEP);
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else if (bus.redirect_valid) begin
                        state_r <= FS_WAIT;
                        pc_r    <= target_s;
                        kill_r  <= 1'b1;
                    end else begin
                        state_r <= FS_WAIT;
                    end
                end
                default: begin
                    state_r <= FS_BOOT;
                    kill_r  <= 1'b0;
                end
            endcase
        end
    end

    fetch_sequencer_fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .flush   (bus.redirect_valid),
        .ready   (bus.inst_ready),
        .data_in (bus.imem_rdata),
        .pc_in   (inflight_pc_r),
        .valid   (buf_valid),
        .data    (buf_data),
        .pc      (buf_pc)
    );

    assign bus.imem_req   = req_s;
    assign bus.imem_addr  = pc_r;
    assign bus.pc_cur     = pc_r;
    assign bus.inst_valid = buf_valid;
    assign bus.inst       = buf_data;
    assign bus.inst_pc    = buf_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: an imem responder with configurable
// latency, a scoreboard of expected (pc, word) pairs, and one task per scenario.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_fetch;
    int          pend_cnt = 0;
    logic [31:0] pend_addr;
    int          resp_lat = 1;

    logic        obs_req, obs_fire, obs_valid;
    logic [31:0] obs_addr, obs_inst, obs_inst_pc, obs_pc;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    // One clock: sample at negedge, score, then drive the responder after posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        obs_req     = bus.imem_req;
        obs_addr    = bus.imem_addr;
        obs_fire    = bus.imem_req && bus.imem_gnt;
        obs_valid   = bus.inst_valid;
        obs_inst    = bus.inst;
        obs_inst_pc = bus.inst_pc;
        obs_pc      = bus.pc_cur;
        if (bus.inst_valid && bus.inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_accept: got inst_pc=%h inst=%h, expected no instruction", bus.inst_pc, bus.inst);
            end else begin
                e = exp_q.pop_front();
                if (bus.inst_pc !== e.pc || bus.inst !== e.word)
                    $display("FAIL sb_accept: got pc=%h inst=%h, expected pc=%h inst=%h",
                             bus.inst_pc, bus.inst, e.pc, e.word);
                else
                    passed++;
            end
        end
        if (obs_fire) begin
            checks++;
            if (bus.imem_addr !== exp_fetch)
                $display("FAIL sb_fetch_addr: got %h, expected %h", bus.imem_addr, exp_fetch);
            else
                passed++;
            if (!bus.redirect_valid) begin
                e.pc   = exp_fetch;
                e.word = mem_word(exp_fetch);
                exp_q.push_back(e);
            end
            exp_fetch = exp_fetch + 32'd4;
        end
        if (bus.redirect_valid) begin
            exp_q.delete();
            exp_fetch = {bus.redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        if (obs_fire) begin
            pend_cnt  = resp_lat;
            pend_addr = obs_addr;
        end
        if (pend_cnt == 1) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr);
        end
        if (pend_cnt > 0) pend_cnt--;
    endtask

    task automatic reset_assert();
        rst                = 1'b1;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        pend_cnt           = 0;
        exp_q.delete();
        exp_fetch          = DEFAULT_RESET_PC;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_assert();
        #1;
        checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b, expected 0", bus.imem_req); else passed++;
        checks++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", bus.inst_valid); else passed++;
        checks++; if (bus.inst !== 32'h0) $display("FAIL reset_inst: got %h, expected 0", bus.inst); else passed++;
        checks++; if (bus.inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h, expected 0", bus.inst_pc); else passed++;
        checks++; if (bus.pc_cur !== 32'h0) $display("FAIL reset_pc_cur: got %h, expected 0", bus.pc_cur); else passed++;
    endtask

    task automatic test_boot_stream();
        int first_req = -1;
        int first_valid = -1;
        int n_fire = 0;
        reset_assert();
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_lat = 1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (obs_req && first_req < 0) first_req = k;
            if (obs_valid && first_valid < 0) first_valid = k;
            if (obs_fire) n_fire++;
        end
        checks++; if (first_req != 1) $display("FAIL boot_first_req: got cycle %0d, expected 1", first_req); else passed++;
        checks++; if (first_valid != 3) $display("FAIL boot_first_valid: got cycle %0d, expected 3", first_valid); else passed++;
        checks++; if (n_fire != 8) $display("FAIL boot_throughput: got %0d fetches, expected 8", n_fire); else passed++;
        checks++; if (obs_pc !== 32'd28) $display("FAIL boot_pc_cur: got %h, expected 0000001c", obs_pc); else passed++;
    endtask

    task automatic test_stall();
        logic found = 1'b0;
        reset_assert();
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b0; resp_lat = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (obs_valid) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || obs_inst_pc !== 32'h0 || obs_inst !== mem_word(32'h0))
            $display("FAIL stall_first: got valid=%b pc=%h inst=%h, expected 1 0 %h", found, obs_inst_pc, obs_inst, mem_word(32'h0));
        else passed++;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_inst !== mem_word(32'h0) ||
                obs_inst_pc !== 32'h0 || obs_pc !== 32'h4)
                $display("FAIL stall_hold: got req=%b valid=%b inst=%h inst_pc=%h pc_cur=%h, expected 0 1 %h 0 4",
                         obs_req, obs_valid, obs_inst, obs_inst_pc, obs_pc, mem_word(32'h0));
            else passed++;
        end
        bus.inst_ready = 1'b1;
        step();
        checks++;
        if (!obs_fire || obs_addr !== 32'h4)
            $display("FAIL stall_resume: got fire=%b addr=%h, expected 1 00000004", obs_fire, obs_addr);
        else passed++;
        for (int k = 0; k < 6; k++) step();
    endtask

    task automatic test_redirect_wait();
        logic have_fire = 1'b0;
        logic early = 1'b0;
        logic got = 1'b0;
        logic [31:0] fire_addr = 32'h0;
        logic [31:0] got_pc = 32'h0;
        reset_assert();
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_lat = 2;
        step();
        step();
        checks++;
        if (!obs_fire || obs_addr !== 32'h0) $display("FAIL redir_wait_fetch0: got fire=%b addr=%h, expected 1 0", obs_fire, obs_addr);
        else passed++;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            if (obs_fire && !have_fire) begin have_fire = 1'b1; fire_addr = obs_addr; end
            if (obs_valid) begin
                if (!have_fire) early = 1'b1;
                else begin got = 1'b1; got_pc = obs_inst_pc; break; end
            end
        end
        checks++; if (!have_fire || fire_addr !== 32'h100) $display("FAIL redir_wait_addr: got %h, expected 00000100", fire_addr); else passed++;
        checks++; if (early) $display("FAIL redir_wait_drop: got stale inst_valid=1, expected 0"); else passed++;
        checks++; if (!got || got_pc !== 32'h100) $display("FAIL redir_wait_inst_pc: got %h, expected 00000100", got_pc); else passed++;
    endtask

    task automatic test_redirect_rvalid();
        int n_valid = 0;
        reset_assert();
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_lat = 1;
        step();
        step();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0203;
        step();
        step();
        checks++;
        if (!obs_fire || obs_addr !== 32'h200 || obs_valid !== 1'b0)
            $display("FAIL redir_rv_fetch: got fire=%b addr=%h valid=%b, expected 1 00000200 0", obs_fire, obs_addr, obs_valid);
        else passed++;
        step();
        checks++; if (obs_valid !== 1'b0) $display("FAIL redir_rv_gap: got valid=%b, expected 0", obs_valid); else passed++;
        step();
        checks++;
        if (obs_valid !== 1'b1 || obs_inst_pc !== 32'h200 || obs_inst !== mem_word(32'h200))
            $display("FAIL redir_rv_inst: got valid=%b pc=%h inst=%h, expected 1 00000200 %h", obs_valid, obs_inst_pc, obs_inst, mem_word(32'h200));
        else passed++;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_valid) n_valid++;
        end
        checks++; if (n_valid != 3) $display("FAIL redir_rv_no_kill: got %0d instructions, expected 3", n_valid); else passed++;
    endtask

    task automatic test_wrap();
        reset_assert();
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_lat = 1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        step();
        checks++;
        if (!obs_fire || obs_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_boot_redirect: got fire=%b addr=%h, expected 1 fffffffc", obs_fire, obs_addr);
        else passed++;
        step();
        step();
        checks++;
        if (obs_valid !== 1'b1 || obs_inst_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_inst_pc: got valid=%b pc=%h, expected 1 fffffffc", obs_valid, obs_inst_pc);
        else passed++;
        checks++;
        if (!obs_fire || obs_addr !== 32'h0 || obs_pc !== 32'h0)
            $display("FAIL wrap_next_addr: got fire=%b addr=%h pc_cur=%h, expected 1 0 0", obs_fire, obs_addr, obs_pc);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        reset_assert();
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_lat = 1;
        for (int k = 0; k < 8; k++) step();
        bus.inst_ready = 1'b0;
        step();
        step();
        step();
        checks++;
        if (obs_valid !== 1'b1 || obs_inst_pc !== 32'hC)
            $display("FAIL midrst_pre: got valid=%b pc=%h, expected 1 0000000c", obs_valid, obs_inst_pc);
        else passed++;
        reset_assert();
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 ||
            bus.inst_pc !== 32'h0 || bus.pc_cur !== 32'h0 || bus.imem_addr !== 32'h0)
            $display("FAIL midrst_clear: got req=%b valid=%b inst=%h inst_pc=%h pc_cur=%h, expected all 0",
                     bus.imem_req, bus.inst_valid, bus.inst, bus.inst_pc, bus.pc_cur);
        else passed++;
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_lat = 2;
        step();
        checks++; if (obs_req !== 1'b0) $display("FAIL midrst_boot: got req=%b, expected 0", obs_req); else passed++;
        step();
        checks++; if (!obs_fire || obs_addr !== 32'h0) $display("FAIL midrst_refetch: got fire=%b addr=%h, expected 1 0", obs_fire, obs_addr); else passed++;
        // Now waiting on a response: reset again while in WAIT.
        reset_assert();
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.pc_cur !== 32'h0 || bus.inst_valid !== 1'b0)
            $display("FAIL waitrst_clear: got req=%b pc_cur=%h valid=%b, expected 0 0 0", bus.imem_req, bus.pc_cur, bus.inst_valid);
        else passed++;
        reset_release();
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; resp_lat = 1;
        step();
        step();
        step();
        step();
        checks++;
        if (obs_valid !== 1'b1 || obs_inst_pc !== 32'h0 || obs_inst !== mem_word(32'h0))
            $display("FAIL waitrst_first: got valid=%b pc=%h inst=%h, expected 1 0 %h", obs_valid, obs_inst_pc, obs_inst, mem_word(32'h0));
        else passed++;
    endtask

    // Scenario sequence and summary.
    initial begin
        #2;
        test_reset();
        test_boot_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected completion");
        $fatal(1);
    end

endmodule
